// File: rtl/ppi_bus_master_if.sv
// Host request/response and 8255-style bus signals of the PPI bus master.
// The master modport is the initiator's view; the slave modport is the host/PPI side.
interface ppi_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] a;
    logic [7:0] bus_dout;
    logic [7:0] bus_din;
    logic       bus_dir;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_din,
        output req_ready, rsp_valid, rsp_rdata, cs_n, rd_n, wr_n, a, bus_dout, bus_dir
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_din,
        input  req_ready, rsp_valid, rsp_rdata, cs_n, rd_n, wr_n, a, bus_dout, bus_dir
    );
endinterface

// File: rtl/ppi_bus_master.sv
// Turns single-beat host requests into timed PPI bus cycles (SETUP/STROBE/HOLD).
// Define PPI_BUS_RECOVERY_EN to insert RECOVERY_CYC forced idle cycles after each HOLD.
module ppi_bus_master #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 2,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    ppi_bus_master_if.master        bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
`ifdef PPI_BUS_RECOVERY_EN
        , ST_RECOVER
`endif
    } state_e;

    localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RECOVER_LD = 4'(RECOVERY_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic [1:0] a_q, a_d;
    logic [7:0] bus_dout_q, bus_dout_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       bus_dir_q, bus_dir_d;
    logic       active_d;
    logic       strobe_d;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        write_d     = write_q;
        a_d         = a_q;
        bus_dout_d  = bus_dout_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    write_d = bus.req_write;
                    a_d     = bus.req_addr;
                    if (bus.req_write) bus_dout_d = bus.req_wdata;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    if (!write_q) rsp_rdata_d = bus.bus_din;
                end
            end
            ST_HOLD: begin
                // Without recovery the counter value in IDLE is a don't-care; accept reloads it.
                if (cnt_q == 4'd0) begin
                    cnt_d = RECOVER_LD;
`ifdef PPI_BUS_RECOVERY_EN
                    state_d = ST_RECOVER;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef PPI_BUS_RECOVERY_EN
            ST_RECOVER: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Pin values are decoded from the next state so they are registered yet cycle-exact.
        active_d    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        strobe_d    = (state_d == ST_STROBE);
        cs_n_d      = !active_d;
        rd_n_d      = !(strobe_d && !write_d);
        wr_n_d      = !(strobe_d && write_d);
        bus_dir_d   = !(active_d && write_d);
        rsp_valid_d = (state_d == ST_HOLD) && (cnt_d == 4'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            a_q         <= 2'b00;
            bus_dout_q  <= 8'h00;
            rsp_rdata_q <= 8'h00;
            rsp_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            bus_dir_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            a_q         <= a_d;
            bus_dout_q  <= bus_dout_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            bus_dir_q   <= bus_dir_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.a         = a_q;
    assign bus.bus_dout  = bus_dout_q;
    assign bus.bus_dir   = bus_dir_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Scoreboard bench for ppi_bus_master: a driver queues expected transactions, a negedge
// monitor checks every bus pin cycle-by-cycle against offsets from the accept cycle.
module tb_ppi_bus_master;
`ifdef PPI_BUS_RECOVERY_EN
    localparam int S = 2, T = 3, H = 2, R = 2;
`else
    localparam int S = 1, T = 2, H = 1, R = 0;
`endif
    localparam int L = S + T + H;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ppi_bus_master_if bus_if();

    ppi_bus_master #(
        .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RECOVERY_CYC(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if.master)
    );

    typedef struct {
        bit         write;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         c0;
    } txn_t;

    txn_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_rsp = -100;
    bit         skip = 1'b1;
    logic [7:0] model_mem[4] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};
    logic [7:0] last_rdata = 8'h00;
    logic [7:0] ppi_mem[4];
    logic [7:0] noise = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) noise <= 8'($urandom);

    // PPI register file model: stores on write strobe, drives data only while rd_n is low.
    initial begin
        ppi_mem = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};
        forever begin
            @(posedge clk);
            if (!bus_if.cs_n && !bus_if.wr_n) ppi_mem[bus_if.a] = bus_if.bus_dout;
        end
    end
    assign bus_if.bus_din = !bus_if.rd_n ? ppi_mem[bus_if.a] : noise;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_cycle();
        txn_t t;
        int   k;
        bit   busy;
        busy = 1'b0;
        k = 0;
        if (sb.size() > 0) begin
            t = sb[0];
            k = cyc - t.c0;
            busy = (k >= 1);
        end
        if (busy) begin
            check("cs_n", 32'(bus_if.cs_n), 32'd0);
            check("a", 32'(bus_if.a), 32'(t.addr));
            check("bus_dir", 32'(bus_if.bus_dir), 32'(!t.write));
            check("rd_n", 32'(bus_if.rd_n), 32'(!(!t.write && k > S && k <= S + T)));
            check("wr_n", 32'(bus_if.wr_n), 32'(!(t.write && k > S && k <= S + T)));
            if (t.write) check("bus_dout", 32'(bus_if.bus_dout), 32'(t.wdata));
            check("req_ready_busy", 32'(bus_if.req_ready), 32'd0);
            check("rsp_valid", 32'(bus_if.rsp_valid), 32'(k == L));
            if (k >= L) begin
                check("rsp_rdata", 32'(bus_if.rsp_rdata), 32'(t.rdata));
                void'(sb.pop_front());
                last_rsp = cyc;
            end
        end else begin
            check("idle_cs_n", 32'(bus_if.cs_n), 32'd1);
            check("idle_rd_n", 32'(bus_if.rd_n), 32'd1);
            check("idle_wr_n", 32'(bus_if.wr_n), 32'd1);
            check("idle_bus_dir", 32'(bus_if.bus_dir), 32'd1);
            check("idle_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
            check("idle_req_ready", 32'(bus_if.req_ready), 32'(cyc > last_rsp + R));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!skip) monitor_cycle();
        end
    end

    // Presents a request, waits for the accept and queues its expected response.
    task automatic issue(input bit w, input logic [1:0] ad, input logic [7:0] wd,
                         input bit keep, output int c0);
        txn_t t;
        bus_if.req_write = w;
        bus_if.req_addr  = ad;
        bus_if.req_wdata = wd;
        bus_if.req_valid = 1'b1;
        c0 = -1;
        for (int i = 0; i < 60 && c0 < 0; i++) begin
            @(negedge clk);
            if (bus_if.req_ready && !reset) c0 = cyc;
        end
        if (c0 < 0) begin
            check("accept_timeout", 32'(bus_if.req_ready), 32'd1);
        end else begin
            if (w) model_mem[ad] = wd;
            else   last_rdata = model_mem[ad];
            t.write = w;
            t.addr  = ad;
            t.wdata = wd;
            t.rdata = last_rdata;
            t.c0    = c0;
            sb.push_back(t);
        end
        @(posedge clk);
        #1;
        if (!keep) bus_if.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        skip = 1'b1;
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_cs_n", 32'(bus_if.cs_n), 32'd1);
            check("rst_rd_n", 32'(bus_if.rd_n), 32'd1);
            check("rst_wr_n", 32'(bus_if.wr_n), 32'd1);
            check("rst_bus_dir", 32'(bus_if.bus_dir), 32'd1);
            check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
            check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
            check("rst_rsp_rdata", 32'(bus_if.rsp_rdata), 32'd0);
        end
        sb.delete();
        last_rsp = -100;
        last_rdata = 8'h00;
        bus_if.req_valid = 1'b0;
        reset = 1'b0;
        skip = 1'b0;
    endtask

    initial begin
        int c0a;
        int c0b;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.req_addr  = 2'b10;
        bus_if.req_wdata = 8'h77;
        do_reset(2);

        // Directed write, then a read of a register preset to A5.
        issue(1'b1, 2'b11, 8'h80, 1'b0, c0a);
        drain();
        issue(1'b0, 2'b01, 8'h00, 1'b0, c0a);
        drain();

        // Request inputs change mid-transaction and must be ignored.
        issue(1'b1, 2'b10, 8'h3E, 1'b0, c0a);
        @(posedge clk);
        #1;
        bus_if.req_addr  = 2'b01;
        bus_if.req_wdata = 8'hC1;
        drain();
        issue(1'b0, 2'b10, 8'h00, 1'b0, c0a);
        drain();

        // req_valid held high across two requests.
        issue(1'b1, 2'b00, 8'h5D, 1'b1, c0a);
        issue(1'b0, 2'b00, 8'h00, 1'b0, c0b);
        check("b2b_gap", 32'(c0b - c0a), 32'(L + 1 + R));
        drain();

        // Reset during cycle 2 of a read aborts it.
        issue(1'b0, 2'b11, 8'h00, 1'b0, c0a);
        @(posedge clk);
        #1;
        do_reset(1);
        issue(1'b0, 2'b11, 8'h00, 1'b0, c0a);
        drain();

        for (int n = 0; n < 40; n++) begin
            bit k;
            k = ($urandom_range(0, 3) == 0);
            issue(1'($urandom), 2'($urandom), 8'($urandom), k, c0a);
            if (!k) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus_if.req_valid = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
